// File: rtl/aes_enc_sched.sv
// aes_enc_sched: sequences key load/expansion and plaintext streaming for a
// pipelined AES-128 core, returning cyphertext in order through a small FIFO.
// Blocks are only issued when their result is guaranteed a FIFO slot, so the
// FIFO write side never needs back-pressure.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no valid key; waiting for a key
// KEY_EXP | expansion pulse sent, waiting for aes_key_done (with timeout)
// RUN     | key valid; accepting plaintext blocks
// DRAIN   | new key accepted; waiting for in-flight blocks to leave the core
module aes_enc_sched #(
  parameter int PIPE_LAT    = 11,
  parameter int OUT_DEPTH   = 4,
  parameter int KEY_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         aes_enable,
  output logic [127:0] aes_key,
  output logic [127:0] aes_plaintext,
  input  logic [127:0] aes_cypher,
  input  logic         aes_key_done,
  output logic         busy,
  output logic         key_err
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int IW = $clog2(PIPE_LAT + 2);
  localparam int TW = $clog2(KEY_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_KEY_EXP, S_RUN, S_DRAIN} state_t;

  state_t          state;
  logic [PIPE_LAT:0] tag;
  logic [IW-1:0]   inflight;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [127:0]    mem [OUT_DEPTH];
  logic [TW-1:0]   tmr;

  logic key_acc;
  logic in_acc;
  logic fifo_wr;
  logic fifo_rd;

  // Credit uses registered counts only, so a pop in the same cycle gives no credit.
  assign key_ready = (state == S_IDLE) || (state == S_RUN);
  assign in_ready  = (state == S_RUN) && ((int'(inflight) + int'(fifo_count)) < OUT_DEPTH);
  assign key_acc   = key_valid && key_ready;
  assign in_acc    = in_valid && in_ready;
  assign fifo_wr   = tag[PIPE_LAT];
  assign out_valid = (fifo_count != '0);
  assign fifo_rd   = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = (state == S_KEY_EXP) || (state == S_DRAIN) ||
                     (inflight != '0) || out_valid;

  // Control FSM: key acceptance, expansion pulse, done/timeout handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      aes_enable <= 1'b0;
      aes_key    <= '0;
      key_err    <= 1'b0;
      tmr        <= '0;
    end else begin
      aes_enable <= 1'b0;
      if (key_acc) begin
        aes_key <= key_in;
        key_err <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (key_acc) begin
            state      <= S_KEY_EXP;
            aes_enable <= 1'b1;
            tmr        <= TW'(KEY_TIMEOUT);
          end
        end
        S_RUN: begin
          if (key_acc) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (inflight == '0) begin
            state      <= S_KEY_EXP;
            aes_enable <= 1'b1;
            tmr        <= TW'(KEY_TIMEOUT);
          end
        end
        S_KEY_EXP: begin
          // done during the pulse cycle belongs to a previous request; ignore it
          if (!aes_enable) begin
            if (aes_key_done) begin
              state <= S_RUN;
            end else if (tmr == TW'(1)) begin
              state   <= S_IDLE;
              key_err <= 1'b1;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Issue path: plaintext register, valid-tag shift register and in-flight count.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag           <= '0;
      inflight      <= '0;
      aes_plaintext <= '0;
    end else begin
      tag <= {tag[PIPE_LAT-1:0], in_acc};
      if (in_acc) aes_plaintext <= in_data;
      case ({in_acc, fifo_wr})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      assert (!(fifo_wr && !fifo_rd && (fifo_count == CW'(OUT_DEPTH))));
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= aes_cypher;
  end

endmodule

// File: tb/tb_aes_enc_sched.sv
// Bench for aes_enc_sched: behavioural AES-128 core model with configurable
// key-done delay, scoreboard of expected cyphertexts, directed scenarios.
module tb_aes_enc_sched;

  localparam int PIPE_LAT    = 11;
  localparam int OUT_DEPTH   = 4;
  localparam int KEY_TIMEOUT = 64;

  logic         clk;
  logic         reset;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         aes_enable;
  logic [127:0] aes_key;
  logic [127:0] aes_plaintext;
  logic [127:0] aes_cypher;
  logic         aes_key_done;
  logic         busy;
  logic         key_err;

  aes_enc_sched #(.PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH), .KEY_TIMEOUT(KEY_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .aes_enable(aes_enable), .aes_key(aes_key), .aes_plaintext(aes_plaintext),
    .aes_cypher(aes_cypher), .aes_key_done(aes_key_done),
    .busy(busy), .key_err(key_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) t[k+4*c] = s[k+4*((c+k)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
          t[4*c+3] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- core model ----------------
  logic [127:0] core_key;
  logic [127:0] cpipe [PIPE_LAT];
  int           done_delay = 10;
  int           done_cnt;

  always @(posedge clk) begin
    if (reset) done_cnt <= 0;
    else if (aes_enable) done_cnt <= done_delay;
    else if (done_cnt != 0) done_cnt <= done_cnt - 1;
    if (aes_enable) core_key <= aes_key;
    cpipe[0] <= aes128(core_key, aes_plaintext);
    for (int i = 1; i < PIPE_LAT; i++) cpipe[i] <= cpipe[i-1];
  end

  assign aes_key_done = (done_cnt == 1);
  assign aes_cypher   = cpipe[PIPE_LAT-1];

  // ---------------- scoreboard monitor ----------------
  logic [127:0] sbq [$];
  logic [127:0] active_key;
  logic [127:0] pending_key;
  logic         stall = 1'b0;
  logic [127:0] stall_data;
  int           n_acc = 0;
  int           n_pop = 0;

  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", (sbq.size() != 0), 1'b1);
        if (sbq.size() != 0) chk("out_data", out_data, sbq.pop_front());
        n_pop++;
      end
      if (in_valid && in_ready) begin
        sbq.push_back(aes128(active_key, in_data));
        n_acc++;
      end
      if (key_valid && key_ready) pending_key = key_in;
      if (aes_key_done) active_key = pending_key;
      stall      = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    chk(tag, (sbq.size() == 0 && !busy), 1'b1);
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int n, t, a0, p0, pulses;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

    reset = 1'b1; key_valid = 1'b0; key_in = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_aes_enable", aes_enable, 1'b0);
    chk("rst_aes_key", aes_key, '0);
    chk("rst_aes_pt", aes_plaintext, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    reset = 1'b0;
    step();

    // 1: key load, known-answer block, latency
    done_delay = 10;
    key_valid = 1'b1; key_in = K1;
    step();
    key_valid = 1'b0;
    chk("t1_enable_pulse", aes_enable, 1'b1);
    chk("t1_aes_key", aes_key, K1);
    chk("t1_key_ready_kexp", key_ready, 1'b0);
    step();
    chk("t1_enable_single", aes_enable, 1'b0);
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk("t1_run_after_done", n, 10);
    out_ready = 1'b1; in_valid = 1'b1; in_data = P1; t = cyc;
    step();
    in_valid = 1'b0;
    chk("t1_aes_pt", aes_plaintext, P1);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("t1_latency", cyc - t, PIPE_LAT + 2);
    chk("t1_kat", out_data, C1);
    step();
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_run", (key_ready && in_ready), 1'b1);

    // 2: 16 blocks streamed, consumer always ready
    a0 = n_acc; p0 = n_pop; n = 0;
    in_valid = 1'b1;
    while (n_acc - a0 < 16 && n < 400) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step(); n++;
    end
    drain("t2_drained");
    chk("t2_accepts", n_acc - a0, 16);
    chk("t2_results", n_pop - p0, 16);

    // 3: consumer stalled, credit limit, one-for-one resume
    out_ready = 1'b0; in_valid = 1'b1; a0 = n_acc;
    for (int i = 0; i < 40; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    chk("t3_credit_accepts", n_acc - a0, OUT_DEPTH);
    chk("t3_in_ready_low", in_ready, 1'b0);
    chk("t3_out_valid", out_valid, 1'b1);
    for (int k = 0; k < 2; k++) begin
      a0 = n_acc;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
        in_data = {$urandom, $urandom, $urandom, $urandom};
        step();
      end
      chk("t3_one_for_one", n_acc - a0, 1);
    end
    drain("t3_drained");

    // 4: rekey with blocks in flight
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    done_delay = 5;
    key_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    in_data = {$urandom, $urandom, $urandom, $urandom};
    step();
    key_valid = 1'b0;
    chk("t4_drain_in_ready", in_ready, 1'b0);
    a0 = n_acc; pulses = 0; n = 0;
    while (!key_ready && n < 100) begin
      if (aes_enable) pulses++;
      step(); n++;
    end
    chk("t4_back_to_run", key_ready, 1'b1);
    chk("t4_one_pulse", pulses, 1);
    chk("t4_no_accept_drain", n_acc - a0, 0);
    n = 0;
    while (n_acc - a0 < 6 && n < 200) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step(); n++;
    end
    drain("t4_drained");

    // 5: key expansion timeout, then recovery
    done_delay = 0;
    key_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    step();
    key_valid = 1'b0;
    n = 0;
    while (!aes_enable && n < 50) begin step(); n++; end
    chk("t5_pulse_seen", aes_enable, 1'b1);
    p0 = cyc; n = 0;
    while (!key_err && n < 200) begin step(); n++; end
    chk("t5_timeout_cycle", cyc - p0, KEY_TIMEOUT + 1);
    chk("t5_idle", {key_ready, in_ready}, 2'b10);
    done_delay = 10;
    key_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    step();
    key_valid = 1'b0;
    chk("t5_err_cleared", key_err, 1'b0);
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk("t5_run", in_ready, 1'b1);
    a0 = n_acc; in_valid = 1'b1; n = 0;
    while (n_acc - a0 < 3 && n < 100) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step(); n++;
    end
    drain("t5_drained");

    // 6: reset with blocks in flight
    out_ready = 1'b0; in_valid = 1'b1; a0 = n_acc; n = 0;
    while (n_acc - a0 < OUT_DEPTH && n < 100) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step(); n++;
    end
    in_valid = 1'b0;
    step();
    chk("t6_busy_before", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_idle", {key_ready, in_ready}, 2'b10);
    chk("t6_key_forgotten", aes_key, '0);
    repeat (20) step();
    chk("t6_no_late_out", out_valid, 1'b0);
    chk("end_sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
